// File: rtl/pc_next_unit_pkg.sv
// Shared next-PC select codes and delay-slot FSM states for the fetch PC unit.
package pc_next_unit_pkg;

    typedef logic [1:0] pc_src_t;

    localparam pc_src_t PC_SRC_SEQ    = 2'd0;
    localparam pc_src_t PC_SRC_BRANCH = 2'd1;
    localparam pc_src_t PC_SRC_JUMP   = 2'd2;
    localparam pc_src_t PC_SRC_JR     = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_next_unit_if.sv
// Control/target inputs and PC outputs of the next-PC unit; master drives, slave is the PC unit.
interface pc_next_unit_if
    import pc_next_unit_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic               stall;
    logic               exception;
    pc_src_t            pc_src;
    logic               branch_taken;
    logic [WIDTH-1:0]   add_result;
    logic [WIDTH-7:0]   jump_idx;
    logic [WIDTH-1:0]   jr_target;
    logic [WIDTH-1:0]   pc;
    logic [WIDTH-1:0]   pc4;
    logic               redirect;
    logic               erro_alinhamento;

    modport master (
        output stall, exception, pc_src, branch_taken, add_result, jump_idx, jr_target,
        input  pc, pc4, redirect, erro_alinhamento
    );

    modport slave (
        input  stall, exception, pc_src, branch_taken, add_result, jump_idx, jr_target,
        output pc, pc4, redirect, erro_alinhamento
    );

endinterface

// File: rtl/pc_next_unit_target_mux.sv
// Combinational 4:1 next-PC target select with JR alignment check; zero latency.
module pc_target_mux
    import pc_next_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_pc4,
    input  pc_src_t          i_pc_src,
    input  logic             i_branch_taken,
    input  logic [WIDTH-1:0] i_add_result,
    input  logic [WIDTH-7:0] i_jump_idx,
    input  logic [WIDTH-1:0] i_jr_target,
    output logic [WIDTH-1:0] o_target,
    output logic             o_taken,
    output logic             o_misalign
);

    always_comb begin
        o_target   = i_pc4;
        o_taken    = 1'b0;
        o_misalign = 1'b0;
        case (i_pc_src)
            PC_SRC_BRANCH: begin
                // An untaken branch falls through as a sequential fetch.
                if (i_branch_taken) begin
                    o_target = i_add_result;
                    o_taken  = 1'b1;
                end
            end
            PC_SRC_JUMP: begin
                o_target = {i_pc4[WIDTH-1:WIDTH-4], i_jump_idx, 2'b00};
                o_taken  = 1'b1;
            end
            PC_SRC_JR: begin
                o_target   = {i_jr_target[WIDTH-1:2], 2'b00};
                o_taken    = 1'b1;
                o_misalign = |i_jr_target[1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_next_unit.sv
// Registered fetch PC with exception/stall/redirect priority; target lands one edge after select.
// BRANCH_DELAY_SLOT_EN: taken redirects first fetch pc+4 (delay slot), then the latched target.
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int               INC          = 4
) (
    input  logic          clk,
    input  logic          reset,
    pc_next_unit_if.slave bus
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_pc4;
    logic [WIDTH-1:0] w_target;
    logic             r_redirect;
    logic             w_redirect_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_taken;
    logic             w_misalign;

    assign w_pc4 = r_pc + WIDTH'(INC);

    pc_target_mux #(.WIDTH(WIDTH)) u_target_mux (
        .i_pc4          (w_pc4),
        .i_pc_src       (bus.pc_src),
        .i_branch_taken (bus.branch_taken),
        .i_add_result   (bus.add_result),
        .i_jump_idx     (bus.jump_idx),
        .i_jr_target    (bus.jr_target),
        .o_target       (w_target),
        .o_taken        (w_taken),
        .o_misalign     (w_misalign)
    );

`ifdef BRANCH_DELAY_SLOT_EN
    pc_state_e        r_state;
    pc_state_e        w_state_nxt;
    logic [WIDTH-1:0] r_pend_tgt;
    logic [WIDTH-1:0] w_pend_tgt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pend_tgt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
        end
    end

    always_comb begin
        w_pc_nxt       = r_pc;
        w_redirect_nxt = 1'b0;
        w_err_nxt      = r_err;
        w_state_nxt    = r_state;
        w_pend_tgt_nxt = r_pend_tgt;
        if (bus.exception) begin
            w_pc_nxt       = EXC_VECTOR;
            w_redirect_nxt = 1'b1;
            w_state_nxt    = ST_IDLE;
        end else if (!bus.stall) begin
            // In PEND the delay-slot instruction's own pc_src is ignored.
            if (r_state == ST_PEND) begin
                w_pc_nxt       = r_pend_tgt;
                w_redirect_nxt = 1'b1;
                w_state_nxt    = ST_IDLE;
            end else begin
                w_pc_nxt = w_pc4;
                if (w_taken) begin
                    w_pend_tgt_nxt = w_target;
                    w_state_nxt    = ST_PEND;
                    w_err_nxt      = r_err | w_misalign;
                end
            end
        end
    end
`else
    always_comb begin
        w_pc_nxt       = r_pc;
        w_redirect_nxt = 1'b0;
        w_err_nxt      = r_err;
        if (bus.exception) begin
            w_pc_nxt       = EXC_VECTOR;
            w_redirect_nxt = 1'b1;
        end else if (!bus.stall) begin
            w_pc_nxt       = w_target;
            w_redirect_nxt = w_taken;
            w_err_nxt      = r_err | w_misalign;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_VECTOR;
            r_redirect <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_redirect <= w_redirect_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign bus.pc               = r_pc;
    assign bus.pc4              = w_pc4;
    assign bus.redirect         = r_redirect;
    assign bus.erro_alinhamento = r_err;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed + random stimulus for pc_next_unit, checked against a behavioural PC model.
module tb_pc_next_unit;

    localparam int          W   = 32;
    localparam logic [31:0] EXC = 32'h8000_0180;

    logic clk;
    logic reset;

    pc_next_unit_if #(.WIDTH(W)) bus ();

    pc_next_unit #(
        .WIDTH        (W),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (EXC),
        .INC          (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_pc;
    logic [31:0] m_pend_tgt;
    bit          m_red;
    bit          m_err;
    bit          m_pend;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got running, want finished)");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = 32'h0;
        m_red      = 1'b0;
        m_err      = 1'b0;
        m_pend     = 1'b0;
        m_pend_tgt = 32'h0;
    endtask

    // One clock edge of the PC as described by its architectural rules.
    task automatic model_edge();
        logic [31:0] seq;
        logic [31:0] tgt;
        bit          taken;
        bit          mis;
        if (reset) begin
            model_reset();
            return;
        end
        seq   = m_pc + 32'd4;
        tgt   = seq;
        taken = 1'b0;
        mis   = 1'b0;
        case (bus.pc_src)
            2'd1: if (bus.branch_taken) begin taken = 1'b1; tgt = bus.add_result; end
            2'd2: begin taken = 1'b1; tgt = (seq & 32'hF000_0000) | ({6'd0, bus.jump_idx} << 2); end
            2'd3: begin taken = 1'b1; tgt = bus.jr_target & 32'hFFFF_FFFC; mis = (bus.jr_target % 4) != 0; end
            default: ;
        endcase
        if (bus.exception) begin
            m_pc   = EXC;
            m_red  = 1'b1;
            m_pend = 1'b0;
        end else if (bus.stall) begin
            m_red = 1'b0;
        end else begin
`ifdef BRANCH_DELAY_SLOT_EN
            if (m_pend) begin
                m_pc   = m_pend_tgt;
                m_red  = 1'b1;
                m_pend = 1'b0;
            end else begin
                m_pc  = seq;
                m_red = 1'b0;
                if (taken) begin
                    m_pend     = 1'b1;
                    m_pend_tgt = tgt;
                    m_err      = m_err | mis;
                end
            end
`else
            m_pc  = tgt;
            m_red = taken;
            m_err = m_err | mis;
`endif
        end
    endtask

    task automatic check_outputs(string tag);
        chk({tag, ".pc"},       bus.pc,                     m_pc);
        chk({tag, ".pc4"},      bus.pc4,                    m_pc + 32'd4);
        chk({tag, ".redirect"}, 32'(bus.redirect),         32'(m_red));
        chk({tag, ".err"},      32'(bus.erro_alinhamento), 32'(m_err));
    endtask

    task automatic drive(bit st, bit ex, logic [1:0] src, bit bt,
                         logic [31:0] add, logic [25:0] idx, logic [31:0] jr);
        bus.stall        = st;
        bus.exception    = ex;
        bus.pc_src       = src;
        bus.branch_taken = bt;
        bus.add_result   = add;
        bus.jump_idx     = idx;
        bus.jr_target    = jr;
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    // Second edge only exists when the delay slot is built in.
    task automatic settle(string tag);
        drive(0, 0, 2'd0, 0, 32'h0, 26'h0, 32'h0);
`ifdef BRANCH_DELAY_SLOT_EN
        cycle(tag);
`endif
    endtask

    logic [31:0] hold_pc;

    initial begin
        reset = 1'b1;
        drive(0, 0, 2'd0, 0, 32'h0, 26'h0, 32'h0);
        model_reset();
        repeat (2) cycle("reset");
        chk("reset_pc", bus.pc, 32'h0);
        reset = 1'b0;

        repeat (3) cycle("seq");
        chk("seq3_pc", bus.pc, 32'hC);

        drive(0, 0, 2'd1, 1, 32'h100, 26'h0, 32'h0);
        cycle("branch");
        settle("branch_ds");
        chk("branch_pc", bus.pc, 32'h100);
        chk("branch_redirect", 32'(bus.redirect), 32'd1);
        cycle("after_branch");

        drive(0, 0, 2'd1, 0, 32'h900, 26'h0, 32'h0);
        cycle("branch_not_taken");

        drive(0, 0, 2'd1, 1, 32'h1000_0000, 26'h0, 32'h0);
        cycle("to_1000");
        settle("to_1000_ds");
        drive(0, 0, 2'd2, 0, 32'h0, 26'h40, 32'h0);
        cycle("jump");
        settle("jump_ds");
        chk("jump_pc", bus.pc, 32'h1000_0100);

        drive(0, 0, 2'd3, 0, 32'h0, 26'h0, 32'h203);
        cycle("jr");
        settle("jr_ds");
        chk("jr_pc", bus.pc, 32'h200);
        chk("jr_err", 32'(bus.erro_alinhamento), 32'd1);
        drive(0, 0, 2'd0, 0, 32'h0, 26'h0, 32'h0);
        repeat (2) cycle("err_sticky");
        chk("err_sticky", 32'(bus.erro_alinhamento), 32'd1);

        hold_pc = m_pc;
        drive(1, 0, 2'd1, 1, 32'h300, 26'h0, 32'h0);
        repeat (3) cycle("stall");
        chk("stall_pc", bus.pc, hold_pc);
        drive(0, 0, 2'd1, 1, 32'h300, 26'h0, 32'h0);
        cycle("stall_release");
        settle("stall_release_ds");
        chk("stall_release_pc", bus.pc, 32'h300);

        drive(1, 1, 2'd1, 1, 32'h500, 26'h0, 32'h0);
        cycle("exc_stall");
        chk("exc_stall_pc", bus.pc, EXC);
        chk("exc_stall_redirect", 32'(bus.redirect), 32'd1);
        drive(0, 0, 2'd0, 0, 32'h0, 26'h0, 32'h0);
        cycle("exc_after");

        drive(0, 0, 2'd1, 1, 32'h600, 26'h0, 32'h0);
        cycle("exc_pend_br");
        drive(0, 1, 2'd0, 0, 32'h0, 26'h0, 32'h0);
        cycle("exc_pend");
        chk("exc_pend_pc", bus.pc, EXC);
        drive(0, 0, 2'd0, 0, 32'h0, 26'h0, 32'h0);
        cycle("exc_pend_gone");
        chk("exc_pend_gone_pc", bus.pc, EXC + 32'd4);

        drive(0, 0, 2'd1, 1, 32'hFFFF_FFFC, 26'h0, 32'h0);
        cycle("to_top");
        settle("to_top_ds");
        chk("top_pc", bus.pc, 32'hFFFF_FFFC);
        cycle("wrap");
        chk("wrap_pc", bus.pc, 32'h0);

        drive(0, 0, 2'd1, 1, 32'h40, 26'h0, 32'h0);
        cycle("to_40");
        settle("to_40_ds");
        chk("at_40_pc", bus.pc, 32'h40);
        #3 reset = 1'b1;
        #1;
        model_reset();
        chk("async_reset_pc", bus.pc, 32'h0);
        chk("async_reset_redirect", 32'(bus.redirect), 32'd0);
        chk("async_reset_err", 32'(bus.erro_alinhamento), 32'd0);
        cycle("reset_hold");
        reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom % 60) == 0;
            drive(($urandom % 5) == 0, ($urandom % 20) == 0, 2'($urandom), 1'($urandom),
                  $urandom & 32'hFFFF_FFFC, 26'($urandom), $urandom);
            cycle("rand");
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
